// File: rtl/canal_lock_ctrl.sv
// Canal lock sequencer: arbitrates passages, equalizes the chamber level with
// the fill/drain valves and opens a gate only when the levels match.
//
// state    | meaning
// IDLE     | no passage, waiting for req_out / req_in
// EQ_SRC   | moving chamber level to the source side level
// OPEN_SRC | source gate open, waiting for boat_entered
// EQ_DST   | moving chamber level to the destination side level
// OPEN_DST | destination gate open, waiting for boat_exited
module canal_lock_ctrl #(
  parameter int               LVL_W     = 14,
  parameter int               TICK_DIV  = 50000,
  parameter logic [LVL_W-1:0] STEP      = 14'd10,
  parameter logic [LVL_W-1:0] LOCK_INIT = 14'd0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [LVL_W-1:0] outside_level,
  input  logic [LVL_W-1:0] inner_level,
  input  logic             req_out,
  input  logic             req_in,
  input  logic             boat_entered,
  input  logic             boat_exited,
  output logic [LVL_W-1:0] lock_level,
  output logic             gate_out_open,
  output logic             gate_in_open,
  output logic             fill_valve,
  output logic             drain_valve,
  output logic             busy,
  output logic             dir_out_to_in
);

  localparam int               CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  typedef enum logic [2:0] {IDLE, EQ_SRC, OPEN_SRC, EQ_DST, OPEN_DST} state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [LVL_W-1:0] lock_q;
  logic             gate_out_q, gate_in_q, fill_q, drain_q, busy_q, dir_q;

  logic             tick;
  logic [LVL_W-1:0] target, diff, step_amt, lock_d;
  logic             below, above;

  assign tick = (cnt_q == CNT_LAST);

  // Difference is formed before stepping so the move can never wrap or overshoot.
  always_comb begin
    if (state_q == EQ_DST) target = dir_q ? inner_level : outside_level;
    else                   target = dir_q ? outside_level : inner_level;
    below    = (lock_q < target);
    above    = (lock_q > target);
    diff     = below ? (target - lock_q) : (lock_q - target);
    step_amt = (diff < STEP) ? diff : STEP;
    lock_d   = below ? (lock_q + step_amt) : (lock_q - step_amt);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= tick ? '0 : cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      lock_q     <= LOCK_INIT;
      gate_out_q <= 1'b0;
      gate_in_q  <= 1'b0;
      fill_q     <= 1'b0;
      drain_q    <= 1'b0;
      busy_q     <= 1'b0;
      dir_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_out || req_in) begin
            // Both waiting: alternate away from the previous passage direction.
            dir_q   <= (req_out && req_in) ? !dir_q : req_out;
            busy_q  <= 1'b1;
            state_q <= EQ_SRC;
          end
        end
        EQ_SRC, EQ_DST: begin
          if (!below && !above) begin
            fill_q  <= 1'b0;
            drain_q <= 1'b0;
            if (state_q == EQ_SRC) begin
              gate_out_q <= dir_q;
              gate_in_q  <= !dir_q;
              state_q    <= OPEN_SRC;
            end else begin
              gate_out_q <= !dir_q;
              gate_in_q  <= dir_q;
              state_q    <= OPEN_DST;
            end
          end else begin
            fill_q  <= below;
            drain_q <= above;
            if (tick) lock_q <= lock_d;
          end
        end
        OPEN_SRC: begin
          if (boat_entered) begin
            gate_out_q <= 1'b0;
            gate_in_q  <= 1'b0;
            state_q    <= EQ_DST;
          end
        end
        OPEN_DST: begin
          if (boat_exited) begin
            gate_out_q <= 1'b0;
            gate_in_q  <= 1'b0;
            busy_q     <= 1'b0;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign lock_level    = lock_q;
  assign gate_out_open = gate_out_q;
  assign gate_in_open  = gate_in_q;
  assign fill_valve    = fill_q;
  assign drain_valve   = drain_q;
  assign busy          = busy_q;
  assign dir_out_to_in = dir_q;

endmodule

// File: tb/tb_canal_lock_ctrl.sv
// Self-checking bench for canal_lock_ctrl: directed passages plus randomized
// passages checked against a passage-level model of the chamber level.
module tb_canal_lock_ctrl;

  localparam int LVL_W    = 14;
  localparam int TICK_DIV = 4;
  localparam int STEP     = 10;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [LVL_W-1:0] outside_level, inner_level;
  logic             req_out, req_in, boat_entered, boat_exited;
  logic [LVL_W-1:0] lock_level;
  logic             gate_out_open, gate_in_open, fill_valve, drain_valve, busy, dir_out_to_in;

  canal_lock_ctrl #(
    .LVL_W(LVL_W), .TICK_DIV(TICK_DIV), .STEP(14'd10), .LOCK_INIT(14'd0)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .outside_level(outside_level), .inner_level(inner_level),
    .req_out(req_out), .req_in(req_in),
    .boat_entered(boat_entered), .boat_exited(boat_exited),
    .lock_level(lock_level),
    .gate_out_open(gate_out_open), .gate_in_open(gate_in_open),
    .fill_valve(fill_valve), .drain_valve(drain_valve),
    .busy(busy), .dir_out_to_in(dir_out_to_in)
  );

  always #5 clk = ~clk;

  int n_checks  = 0;
  int n_err     = 0;
  int inv_viol  = 0;
  int m_lock    = 0;
  bit m_dir     = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if ((gate_out_open && gate_in_open) ||
          ((gate_out_open || gate_in_open) && (fill_valve || drain_valve)) ||
          (fill_valve && drain_valve))
        inv_viol++;
    end
  end

  // Follow the chamber through one equalization until a gate opens; every level
  // change must be one tick apart and move by min(STEP, remaining distance).
  task automatic equalize(input int target, input bit src_leg, input string tag);
    int d, nxt, exp_steps, steps, cyc, last_chg, prev, budget;
    bit opened, any_valve, exp_out;
    d         = (target > m_lock) ? target - m_lock : m_lock - target;
    exp_steps = (d + STEP - 1) / STEP;
    budget    = (exp_steps + 3) * TICK_DIV + 8;
    steps = 0; cyc = 1; last_chg = -1; prev = m_lock;
    opened = 1'b0; any_valve = 1'b0;
    while (!opened && cyc <= budget) begin
      if (fill_valve || drain_valve) any_valve = 1'b1;
      if (int'(lock_level) != prev) begin
        d   = (target > m_lock) ? target - m_lock : m_lock - target;
        nxt = (target > m_lock) ? m_lock + imin(d, STEP) : m_lock - imin(d, STEP);
        chk({tag, "-level"}, 32'(lock_level), nxt);
        chk({tag, "-valve"}, {fill_valve, drain_valve}, (target > m_lock) ? 2'b10 : 2'b01);
        if (last_chg >= 0) chk({tag, "-tickgap"}, cyc - last_chg, TICK_DIV);
        last_chg = cyc;
        steps++;
        m_lock = nxt;
        prev   = int'(lock_level);
      end
      if (gate_out_open || gate_in_open) opened = 1'b1;
      else begin
        @(negedge clk);
        cyc++;
      end
    end
    exp_out = src_leg ? m_dir : !m_dir;
    chk({tag, "-opened"}, opened, 1);
    chk({tag, "-gate"}, {gate_out_open, gate_in_open}, {exp_out, !exp_out});
    chk({tag, "-final"}, 32'(lock_level), target);
    chk({tag, "-steps"}, steps, exp_steps);
    chk({tag, "-valves_off"}, {fill_valve, drain_valve}, 0);
    if (exp_steps == 0) begin
      chk({tag, "-no_valve"}, any_valve, 0);
      chk({tag, "-open_in_2"}, (cyc <= 2), 1);
    end
  endtask

  task automatic passage(input bit ro, input bit ri, input bit hold, input int lo,
                         input int li, input bit spur, input string tag);
    bit exp_dir;
    outside_level = LVL_W'(lo);
    inner_level   = LVL_W'(li);
    if (spur) begin
      boat_entered = 1'b1;
      @(negedge clk);
      boat_entered = 1'b0;
      @(negedge clk);
      chk({tag, "-idle_spur_busy"}, busy, 0);
      chk({tag, "-idle_spur_lvl"}, 32'(lock_level), m_lock);
    end
    req_out = ro;
    req_in  = ri;
    exp_dir = (ro && ri) ? !m_dir : ro;
    m_dir   = exp_dir;
    @(negedge clk);
    if (!hold) begin
      req_out = 1'b0;
      req_in  = 1'b0;
    end
    chk({tag, "-dir"}, dir_out_to_in, exp_dir);
    chk({tag, "-busy"}, busy, 1);
    equalize(exp_dir ? lo : li, 1'b1, {tag, "-src"});
    if (spur) begin
      boat_exited = 1'b1;
      @(negedge clk);
      boat_exited = 1'b0;
      @(negedge clk);
      chk({tag, "-src_spur_gate"}, {gate_out_open, gate_in_open}, {exp_dir, !exp_dir});
    end
    boat_entered = 1'b1;
    @(negedge clk);
    boat_entered = 1'b0;
    chk({tag, "-src_closed"}, {gate_out_open, gate_in_open}, 0);
    equalize(exp_dir ? li : lo, 1'b0, {tag, "-dst"});
    boat_exited = 1'b1;
    @(negedge clk);
    boat_exited = 1'b0;
    chk({tag, "-done_busy"}, busy, 0);
    chk({tag, "-done_gates"}, {gate_out_open, gate_in_open}, 0);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    rst_n = 1'b0;
    outside_level = '0; inner_level = '0;
    req_out = 1'b0; req_in = 1'b0; boat_entered = 1'b0; boat_exited = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_level", 32'(lock_level), 0);
    chk("rst_outs", {gate_out_open, gate_in_open, fill_valve, drain_valve, busy, dir_out_to_in}, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_busy", busy, 0);

    passage(1'b1, 1'b0, 1'b0, 30, 100, 1'b0, "o2i");
    passage(1'b0, 1'b1, 1'b0, 95, 100, 1'b0, "nonmul");
    passage(1'b1, 1'b0, 1'b0, 95, 50, 1'b1, "eq95");
    passage(1'b1, 1'b0, 1'b0, 50, 0, 1'b0, "eq50");

    for (int k = 0; k < 8; k++) begin
      int sel;
      sel = $urandom_range(0, 2);
      passage(sel != 1, sel != 0, 1'b0, $urandom_range(0, 400), $urandom_range(0, 400),
              1'($urandom_range(0, 1)), $sformatf("rnd%0d", k));
    end
    passage(1'b1, 1'b0, 1'b0, 16383, 16379, 1'b0, "maxlvl");

    // Async reset in the middle of a fill.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    m_lock = 0; m_dir = 1'b0;
    outside_level = 14'd100; inner_level = 14'd0;
    req_out = 1'b1;
    @(negedge clk);
    req_out = 1'b0;
    n = 0;
    while (lock_level != 14'd40 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("midfill_reach40", 32'(lock_level), 40);
    chk("midfill_fill", fill_valve, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_level", 32'(lock_level), 0);
    chk("arst_outs", {gate_out_open, gate_in_open, fill_valve, drain_valve, busy, dir_out_to_in}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("arst_idle_busy", busy, 0);
    chk("arst_idle_level", 32'(lock_level), 0);

    passage(1'b1, 1'b1, 1'b1, 60, 20, 1'b0, "both1");
    passage(1'b1, 1'b1, 1'b1, 60, 20, 1'b0, "both2");
    req_out = 1'b0;
    req_in  = 1'b0;
    repeat (3) @(negedge clk);
    chk("both_end_busy", busy, 0);

    chk("invariants", inv_viol, 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
